// File: rtl/flopr_pipe.sv
// flopr_pipe: DEPTH-stage data pipeline with per-stage valid bits, stall,
// synchronous flush and a registered count of occupied stages.
// Stage 0 is the input stage; stage DEPTH-1 drives q/q_valid directly.
module flopr_pipe #(
    parameter int               WIDTH     = 64,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Next-state: flush beats enable; stalled edges hold everything.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        valid_d = valid_q;
        count_d = count_q;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RESET_VAL;
            end
            valid_d = '0;
            count_d = '0;
        end else if (en) begin
            data_d[0]  = d;
            valid_d[0] = d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            // A valid entry entering while a valid one leaves keeps the count
            // constant, which also covers the full-pipe drop case.
            if (d_valid && !valid_q[DEPTH-1]) begin
                count_d = count_q + CNT_ONE;
            end else if (!d_valid && valid_q[DEPTH-1]) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Stage registers and occupancy counter, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign q       = data_q[DEPTH-1];
    assign q_valid = valid_q[DEPTH-1];
    assign count   = count_q;

endmodule

// File: tb/tb_flopr_pipe.sv
// Self-checking bench for flopr_pipe (WIDTH=64, DEPTH=4, RESET_VAL=0).
module tb_flopr_pipe;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    // Reference model: m_data[DEPTH-1] is the output stage.
    logic [WIDTH-1:0] m_data [DEPTH];
    logic             m_vld  [DEPTH];
    logic [WIDTH-1:0] sb [$];
    logic             sb_pop;

    typedef struct {
        logic             en;
        logic             flush;
        logic [WIDTH-1:0] d;
        logic             dv;
        logic [WIDTH-1:0] exp_q;
        logic             exp_qv;
        int               exp_cnt;
    } vec_t;

    vec_t vecs [16];

    flopr_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL('0)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += (m_vld[i] ? 1 : 0);
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_vld[i]  = 1'b0;
        end
        sb.delete();
    endtask

    // Drive at the falling edge, advance one rising edge, check 1 ns later.
    task automatic cycle(input logic e, input logic f, input logic [WIDTH-1:0] dd, input logic dv);
        logic [WIDTH-1:0] exp_sb;
        en = e; flush = f; d = dd; d_valid = dv;
        @(posedge clk);
        sb_pop = 1'b0;
        if (f) begin
            model_clear();
        end else if (e) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                m_data[i] = m_data[i-1];
                m_vld[i]  = m_vld[i-1];
            end
            m_data[0] = dd;
            m_vld[0]  = dv;
            if (dv) sb.push_back(dd);
            sb_pop = m_vld[DEPTH-1];
        end
        #1;
        chk("q", q, m_data[DEPTH-1]);
        chk("q_valid", {63'b0, q_valid}, {63'b0, m_vld[DEPTH-1]});
        chk("count", {61'b0, count}, 64'(model_count()));
        if (sb_pop) begin
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_sb = sb.pop_front();
                chk("scoreboard_data", q, exp_sb);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // Long table: fill, full-pipe drop, stall, drain with bubbles.
        vecs[0]  = '{1, 0, 64'h10,  1, 64'h0,   0, 1};
        vecs[1]  = '{1, 0, 64'h12,  1, 64'h0,   0, 2};
        vecs[2]  = '{1, 0, 64'h123, 1, 64'h0,   0, 3};
        vecs[3]  = '{1, 0, 64'h128, 1, 64'h10,  1, 4};
        vecs[4]  = '{1, 0, 64'h142, 1, 64'h12,  1, 4};
        vecs[5]  = '{1, 0, 64'hA,   1, 64'h123, 1, 4};
        vecs[6]  = '{1, 0, 64'hB,   1, 64'h128, 1, 4};
        vecs[7]  = '{1, 0, 64'hC,   1, 64'h142, 1, 4};
        vecs[8]  = '{1, 0, 64'hD,   1, 64'hA,   1, 4};
        vecs[9]  = '{0, 0, 64'hE,   1, 64'hA,   1, 4};
        vecs[10] = '{0, 0, 64'hF,   0, 64'hA,   1, 4};
        vecs[11] = '{0, 0, 64'h99,  1, 64'hA,   1, 4};
        vecs[12] = '{1, 0, 64'h20,  0, 64'hB,   1, 3};
        vecs[13] = '{1, 0, 64'h21,  0, 64'hC,   1, 2};
        vecs[14] = '{1, 0, 64'h22,  0, 64'hD,   1, 1};
        vecs[15] = '{1, 0, 64'h23,  0, 64'h20,  0, 0};

        reset = 1'b0; en = 1'b1; flush = 1'b0; d = '0; d_valid = 1'b1; sb_pop = 1'b0;
        model_clear();

        // Reset held for 5 edges while inputs toggle.
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            d = 64'(i);
            @(posedge clk);
            #1;
            chk("rst_q", q, 64'h0);
            chk("rst_q_valid", {63'b0, q_valid}, 64'h0);
            chk("rst_count", {61'b0, count}, 64'h0);
        end
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].en, vecs[i].flush, vecs[i].d, vecs[i].dv);
            chk("tbl_q", q, vecs[i].exp_q);
            chk("tbl_q_valid", {63'b0, q_valid}, {63'b0, vecs[i].exp_qv});
            chk("tbl_count", {61'b0, count}, 64'(vecs[i].exp_cnt));
        end

        // Alternating valid / bubble; occupancy settles at 2.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 64'h1772 + 64'(i) * 64'habc12, (i % 2 == 0));
            if (i >= 4) chk("alt_q_valid", {63'b0, q_valid}, {63'b0, (i % 2 == 1)});
        end
        chk("alt_count", {61'b0, count}, 64'd2);

        // Flush with en=0 at count 3, then 4-edge latency of next entry.
        cycle(1'b1, 1'b1, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 64'h31, 1'b1);
        cycle(1'b1, 1'b0, 64'h32, 1'b1);
        cycle(1'b1, 1'b0, 64'h33, 1'b1);
        chk("pre_flush_count", {61'b0, count}, 64'd3);
        cycle(1'b0, 1'b1, 64'h34, 1'b1);
        chk("flush_q", q, 64'h0);
        chk("flush_q_valid", {63'b0, q_valid}, 64'h0);
        chk("flush_count", {61'b0, count}, 64'h0);
        cycle(1'b1, 1'b0, 64'h55, 1'b1);
        cycle(1'b1, 1'b0, 64'h56, 1'b0);
        cycle(1'b1, 1'b0, 64'h57, 1'b0);
        chk("post_flush_early_valid", {63'b0, q_valid}, 64'h0);
        cycle(1'b1, 1'b0, 64'h58, 1'b0);
        chk("post_flush_q", q, 64'h55);
        chk("post_flush_q_valid", {63'b0, q_valid}, 64'h1);

        // Asynchronous reset mid-operation with a full pipe.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 64'h60 + 64'(i), 1'b1);
        chk("pre_areset_count", {61'b0, count}, 64'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_q", q, 64'h0);
        chk("areset_q_valid", {63'b0, q_valid}, 64'h0);
        chk("areset_count", {61'b0, count}, 64'h0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 64'h77, 1'b1);
        chk("first_edge_count", {61'b0, count}, 64'd1);

        // Random traffic against the model and scoreboard.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
